dcnt_wrap_monitor: RTL and testbench
====================================

Name: dcnt_wrap_monitor

Overview:
- Sits directly downstream of the 4-bit free-running down counter and consumes its `out` bus every clock.
- Checks that the count decrements by exactly one per cycle and counts wrap-arounds (0 -> max).
- Logs each wrap or step error as an event record in a small FIFO.
- A consumer drains the FIFO through a valid/ready interface.

Parameters:
- WIDTH, 4, width of the monitored count bus.
- SEQ_W, 4, width of the wrap counter and the sequence field of each event.
- DEPTH, 4, event FIFO depth in entries (power of two, >= 2).

Ports:
- clk  in  1  single system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- cnt_in  in  WIDTH  count value from the upstream down counter, sampled every posedge.
- evt_ready  in  1  consumer accepts the head event when high together with evt_valid.
- evt_valid  out  1  FIFO not empty; evt_data is valid.
- evt_data  out  2+SEQ_W  head event: [SEQ_W+1:SEQ_W] type, [SEQ_W-1:0] seq.
- wrap_count  out  SEQ_W  number of wraps seen since reset, modulo 2^SEQ_W.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- armed  out  1  high once a first sample has been captured after reset.

Behaviour:
- Reset (async assert, sync release):
  - armed=0, prev=0, wrap_count=0, overflow=0.
  - FIFO emptied (evt_valid=0), evt_data=0.
  - Reset mid-operation discards all queued events.
- Arming:
  - On the first posedge with reset low, cnt_in is loaded into prev and armed goes to 1.
  - No check and no event on that edge.
- Tracking (armed=1), at every posedge:
  - exp = prev - 1 modulo 2^WIDTH.
  - WRAP: prev==0 and cnt_in=={WIDTH{1}}. wrap_count increments, wrapping at 2^SEQ_W. Push type 2'b01, seq = incremented wrap_count.
  - STEP_ERR: cnt_in != exp. Push type 2'b10, seq = current (unchanged) wrap_count. A held value (cnt_in==prev) is a STEP_ERR.
  - Otherwise: no push.
  - prev <= cnt_in in all cases.
  - WRAP and STEP_ERR are mutually exclusive by construction.
- Latency:
  - An event detected at edge N is written at edge N.
  - evt_valid/evt_data reflect it after edge N (visible in cycle N+1) if the FIFO was empty.
  - No combinational bypass from cnt_in to evt_*.
- FIFO rules:
  - Pop when evt_valid && evt_ready at posedge.
  - evt_data always shows the head entry; it holds stable while evt_valid && !evt_ready.
  - Push and pop on the same edge are both performed; occupancy is unchanged.
  - Push when full with no pop: event dropped, overflow<=1, wrap_count still updates.
  - Push when full with simultaneous pop: accepted, no overflow.
  - Pop when empty: ignored.
- overflow clears only on reset.
- Occupancy counter width is log2(DEPTH)+1; read/write pointers wrap at DEPTH.

Optional Feature:
- Macro: DCNT_MON_ZERO_EVT_EN.
- When defined:
  - Each edge where armed and cnt_in==0 and cnt_in==exp (a legal arrival at zero) pushes type 2'b11, seq = current wrap_count.
  - This is the terminal-count notification for the downstream timer.
  - Same FIFO/overflow rules apply.
- When undefined: type 2'b11 is never produced and the zero-detect logic is absent.

Test Plan:
- Reset 1 for 10 ns, then clean count 15,14,...,0,15 (one value per 10 ns clock), evt_ready=1 -> armed=1 after first edge; exactly one event {01,0001}; wrap_count=1; overflow=0. With DCNT_MON_ZERO_EVT_EN, additionally one {11,0000} one cycle before the wrap event.
- Sequence 9,8,8,7: one STEP_ERR event {10,0000} on the repeated 8; a second STEP_ERR on 8->7? No: exp=7, so only one event total; wrap_count=0.
- evt_ready=0, five injected step errors (9,5,9,5,9,5) with DEPTH=4 -> evt_valid=1 and occupancy 4; overflow=1 after the 5th; evt_data holds the first error stable. Then evt_ready=1 -> exactly 4 events drain and evt_valid=0.
- FIFO full, with an error push and evt_ready=1 on the same edge -> occupancy stays 4; overflow stays 0.
- 17 clean full down-count cycles -> wrap_count goes 15 then wraps to 0; the 16th wrap event has seq=0000.
- Assert reset mid-stream with 3 events queued -> evt_valid=0, wrap_count=0, overflow=0, armed=0 immediately (before the next clk edge); first post-reset sample produces no event.

Source files
------------

// File: rtl/dcnt_wrap_monitor.sv
// dcnt_wrap_monitor: checks a down-counter stream for unit steps, counts wraps, queues events in a FIFO.
// Optional zero-arrival events are enabled by defining DCNT_MON_ZERO_EVT_EN.
module dcnt_wrap_monitor #(
    parameter int WIDTH = 4,
    parameter int SEQ_W = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [SEQ_W+1:0] evt_data,
    output logic [SEQ_W-1:0] wrap_count,
    output logic             overflow,
    output logic             armed
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = SEQ_W + 2;

    logic             armed_q;
    logic [WIDTH-1:0] prev_q;
    logic [SEQ_W-1:0] wrap_q, wrap_d;
    logic             ovf_q;
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0] exp_v;
    logic [EW-1:0]    evt_d;
    logic             is_wrap, is_err, is_zero, push, pop, full, do_push;

    always_comb begin
        exp_v   = prev_q - {{(WIDTH-1){1'b0}}, 1'b1};
        is_wrap = armed_q && (prev_q == '0) && (cnt_in == '1);
        is_err  = armed_q && (cnt_in != exp_v);
`ifdef DCNT_MON_ZERO_EVT_EN
        is_zero = armed_q && (cnt_in == '0) && (cnt_in == exp_v);
`else
        is_zero = 1'b0;
`endif
        wrap_d  = wrap_q + {{(SEQ_W-1){1'b0}}, is_wrap};
        evt_d   = is_wrap ? {2'b01, wrap_d} : is_err ? {2'b10, wrap_q} : {2'b11, wrap_q};
        push    = is_wrap || is_err || is_zero;
        pop     = (cnt_q != '0) && evt_ready;
        full    = cnt_q == (AW+1)'(DEPTH);
        // a full FIFO still accepts a push when the head leaves on the same edge
        do_push = push && (!full || pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b0;
            prev_q  <= '0;
            wrap_q  <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            armed_q <= 1'b1;
            prev_q  <= cnt_in;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_q | (push && full && !pop);
            wr_q    <= wr_q + AW'(do_push);
            rd_q    <= rd_q + AW'(pop);
            cnt_q   <= cnt_q + (AW+1)'(do_push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= evt_d;
    end

    assign evt_valid  = cnt_q != '0;
    assign evt_data   = evt_valid ? mem_q[rd_q] : '0;
    assign wrap_count = wrap_q;
    assign overflow   = ovf_q;
    assign armed      = armed_q;
endmodule

// File: tb/tb_dcnt_wrap_monitor.sv
// tb_dcnt_wrap_monitor: directed self-checking bench for dcnt_wrap_monitor (default build).
module tb_dcnt_wrap_monitor;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cnt_in = 4'd0;
    logic       evt_ready = 1'b1;
    logic       evt_valid, overflow, armed;
    logic [5:0] evt_data;
    logic [3:0] wrap_count;
    int checks = 0;
    int errors = 0;

    dcnt_wrap_monitor dut (
        .clk(clk), .reset(reset), .cnt_in(cnt_in), .evt_ready(evt_ready),
        .evt_valid(evt_valid), .evt_data(evt_data), .wrap_count(wrap_count),
        .overflow(overflow), .armed(armed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] v);
        cnt_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #9;
        check("rst_armed", armed, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_data", evt_data, 0);
        check("rst_wrap", wrap_count, 0);
        check("rst_ovf", overflow, 0);
        #1 reset = 1'b0;

        // clean count 15..0,15 with a single wrap event
        step(4'd15);
        check("t1_armed", armed, 1);
        check("t1_arm_noevt", evt_valid, 0);
        for (int v = 14; v >= 0; v--) step(4'(v));
        check("t1_no_evt", evt_valid, 0);
        step(4'd15);
        check("t1_wrap_valid", evt_valid, 1);
        check("t1_wrap_data", evt_data, 6'h11);
        check("t1_wrap_count", wrap_count, 1);
        check("t1_ovf", overflow, 0);
        step(4'd14);
        check("t1_drained", evt_valid, 0);

        // 9,8,8,7: one step error on the held 8
        do_reset();
        step(4'd9);
        step(4'd8);
        check("t2_ok", evt_valid, 0);
        step(4'd8);
        check("t2_err_valid", evt_valid, 1);
        check("t2_err_data", evt_data, 6'h20);
        step(4'd7);
        check("t2_single", evt_valid, 0);
        check("t2_wrap", wrap_count, 0);

        // five errors into a 4-deep FIFO with no consumer
        do_reset();
        evt_ready = 1'b0;
        step(4'd9);
        step(4'd5);
        check("t3_first_data", evt_data, 6'h20);
        step(4'd9);
        step(4'd5);
        step(4'd9);
        check("t3_full_valid", evt_valid, 1);
        check("t3_full_ovf", overflow, 0);
        step(4'd5);
        check("t3_ovf", overflow, 1);
        check("t3_hold_data", evt_data, 6'h20);
        evt_ready = 1'b1;
        step(4'd4);
        check("t3_drain1", evt_valid, 1);
        step(4'd3);
        check("t3_drain2", evt_valid, 1);
        step(4'd2);
        check("t3_drain3", evt_valid, 1);
        step(4'd1);
        check("t3_drain4", evt_valid, 0);
        check("t3_ovf_sticky", overflow, 1);

        // full FIFO with push and pop on the same edge
        do_reset();
        evt_ready = 1'b0;
        step(4'd9);
        step(4'd5);
        step(4'd9);
        step(4'd5);
        step(4'd9);
        evt_ready = 1'b1;
        step(4'd5);
        check("t4_ovf", overflow, 0);
        step(4'd4);
        check("t4_drain1", evt_valid, 1);
        step(4'd3);
        check("t4_drain2", evt_valid, 1);
        step(4'd2);
        check("t4_drain3", evt_valid, 1);
        step(4'd1);
        check("t4_drain4", evt_valid, 0);

        // 17 full down-count cycles, wrap counter rolls over
        do_reset();
        step(4'd15);
        for (int w = 1; w <= 17; w++) begin
            for (int v = 14; v >= 0; v--) step(4'(v));
            step(4'd15);
            check("t5_wrap_count", wrap_count, 32'(w % 16));
            check("t5_wrap_data", evt_data, 32'h10 | 32'(w % 16));
        end
        check("t5_ovf", overflow, 0);

        // async reset with three queued events
        evt_ready = 1'b0;
        step(4'd9);
        step(4'd5);
        step(4'd9);
        check("t6_queued", evt_valid, 1);
        check("t6_wrap_pre", wrap_count, 1);
        reset = 1'b1;
        #1;
        check("t6_async_valid", evt_valid, 0);
        check("t6_async_wrap", wrap_count, 0);
        check("t6_async_ovf", overflow, 0);
        check("t6_async_armed", armed, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4'd3);
        check("t6_rearm", armed, 1);
        check("t6_no_evt", evt_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
